instr_fetch: RTL

Instruction fetch front end. Owns the PC, issues word reads to the memory controller and presents one instruction at a time to the decoder.
- Uses the decoder's IF_success/instr/stall_RS handshake; this block drives the other end of it.
- Redirects on jump/flush requests from the commit side.
- No branch prediction: next PC is always PC+4.

---
 rtl/instr_fetch_if.sv | 59 +++++
 rtl/instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the decoder handshake, the memory-controller read channel and the
// commit-side redirect into one interface for the instruction fetch unit.
//
// Signals:
//   stall_RS    decoder/RS cannot accept an instruction this cycle
//   IF_success  instr/pc_out hold a valid instruction for the decoder
//   instr       instruction word
//   pc_out      PC of the instruction on instr
//   mem_req     word read request to the memory controller
//   mem_addr    word-aligned read address
//   mem_done    one-cycle pulse, mem_data valid for the outstanding request
//   mem_data    returned word
//   jump_en     redirect request (one-cycle pulse)
//   jump_pc     word-aligned redirect target
//
// Modports:
//   master  the fetch unit side
//   slave   the environment side (decoder, memory controller, commit)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        stall_RS;
  logic        IF_success;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        jump_en;
  logic [31:0] jump_pc;

  modport master (
    input  stall_RS,
    input  mem_done,
    input  mem_data,
    input  jump_en,
    input  jump_pc,
    output IF_success,
    output instr,
    output pc_out,
    output mem_req,
    output mem_addr
  );

  modport slave (
    output stall_RS,
    output mem_done,
    output mem_data,
    output jump_en,
    output jump_pc,
    input  IF_success,
    input  instr,
    input  pc_out,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch front end. Owns the PC, issues one word read at a time to
// the memory controller and holds one instruction for the decoder until it is
// accepted. No branch prediction: the next PC is always PC+4 unless the commit
// side redirects with jump_en.
//
// Optional feature macro: ICACHE_EN
//   Defined   - a direct-mapped instruction cache of ICACHE_LINES words is
//               consulted in IDLE; hits skip the memory request.
//   Undefined - every fetch goes to memory.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   rdy   global ready; when low every register holds its value
//   bus   instr_fetch_if.master (decoder handshake, memory read channel,
//         redirect)
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   ICACHE_LINES  number of cache lines (power of 2), used with ICACHE_EN
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic        if_success_q, if_success_d;
  logic [31:0] instr_q,      instr_d;
  logic [31:0] pc_out_q,     pc_out_d;
  logic        mem_req_q,    mem_req_d;
  logic [31:0] mem_addr_q,   mem_addr_d;

  // Cache lookup result for the current PC (always a miss without the cache).
  logic        hit_s;
  logic [31:0] cache_rdata_s;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             cache_data_q  [ICACHE_LINES];
  logic [TAG_W-1:0]        cache_tag_q   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cache_valid_q;

  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic             fill_s;

  assign rd_idx_s = pc_q[IDX_W+1:2];
  assign rd_tag_s = pc_q[31:IDX_W+2];
  // Fills are keyed by the address actually requested, not by pc_q, because a
  // jump in DROP has already moved pc_q to the new target.
  assign wr_idx_s = mem_addr_q[IDX_W+1:2];
  assign wr_tag_s = mem_addr_q[31:IDX_W+2];
  // Stale DROP data is still correct for its own address, so it fills too.
  assign fill_s   = bus.mem_done && ((state_q == WAIT) || (state_q == DROP));

  assign hit_s         = cache_valid_q[rd_idx_s] && (cache_tag_q[rd_idx_s] == rd_tag_s);
  assign cache_rdata_s = cache_data_q[rd_idx_s];

  // Valid bits: cleared only by reset, set on every fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= '0;
    end else if (rdy && fill_s) begin
      cache_valid_q[wr_idx_s] <= 1'b1;
    end else begin
      cache_valid_q <= cache_valid_q;
    end
  end

  // Data and tag storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (rdy && fill_s) begin
      cache_data_q[wr_idx_s] <= bus.mem_data;
      cache_tag_q[wr_idx_s]  <= wr_tag_s;
    end
  end
`else
  assign hit_s         = 1'b0;
  assign cache_rdata_s = 32'h0;
`endif

  // Next-state and next-output logic of the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_success_d = if_success_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.jump_en) begin
          pc_d         = bus.jump_pc;
          if_success_d = 1'b0;
        end else if (hit_s) begin
          instr_d      = cache_rdata_s;
          pc_out_d     = pc_q;
          if_success_d = 1'b1;
          state_d      = HOLD;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (bus.mem_done) begin
          mem_req_d = 1'b0;
          if (bus.jump_en) begin
            // Data arrives together with the redirect: it is stale, drop it.
            pc_d         = bus.jump_pc;
            if_success_d = 1'b0;
            state_d      = IDLE;
          end else begin
            instr_d      = bus.mem_data;
            pc_out_d     = pc_q;
            if_success_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (bus.jump_en) begin
          // Requests cannot be aborted; wait for the data and discard it.
          pc_d    = bus.jump_pc;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        // A redirect wins over a handoff on the same edge.
        if (bus.jump_en) begin
          pc_d         = bus.jump_pc;
          if_success_d = 1'b0;
          state_d      = IDLE;
        end else if (!bus.stall_RS) begin
          if_success_d = 1'b0;
          pc_d         = pc_q + 32'd4;
          state_d      = IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      DROP: begin
        if (bus.jump_en) begin
          pc_d = bus.jump_pc;
        end else begin
          pc_d = pc_q;
        end
        if (bus.mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = DROP;
        end
      end

      default: begin
        state_d      = IDLE;
        if_success_d = 1'b0;
        mem_req_d    = 1'b0;
      end
    endcase
  end

  // FSM state and all registered outputs; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      if_success_q <= 1'b0;
      instr_q      <= 32'h0;
      pc_out_q     <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_success_q <= if_success_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end else begin
      state_q      <= state_q;
      pc_q         <= pc_q;
      if_success_q <= if_success_q;
      instr_q      <= instr_q;
      pc_out_q     <= pc_out_q;
      mem_req_q    <= mem_req_q;
      mem_addr_q   <= mem_addr_q;
    end
  end

  assign bus.IF_success = if_success_q;
  assign bus.instr      = instr_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule
